// File: rtl/div_unit.sv
// div_unit -- multi-cycle radix-2 restoring divider for DIV/DIVU.
//
// The divider takes its operands when a request is accepted. It then
// performs one quotient bit per clock and presents {remainder, quotient}
// with a ready flag. Signed division works on magnitudes, and the signs
// are fixed up in the final cycle. A zero divisor skips the iterations
// and returns zero.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           asynchronous reset, active-low
//   signed_div_i  1 = two's-complement division, 0 = unsigned
//   opdata1_i     dividend, sampled only when a request is accepted
//   opdata2_i     divisor, sampled only when a request is accepted
//   start_i       request; the requester holds it until it has consumed ready_o
//   annul_i       abort an in-flight division, and block acceptance while high
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t               state_reg,   state_next;
  logic [CW-1:0]        cnt_reg,     cnt_next;
  logic [2*WIDTH:0]     work_reg,    work_next;
  logic [WIDTH-1:0]     divisor_reg, divisor_next;
  logic                 signed_reg,  signed_next;
  logic                 sign1_reg,   sign1_next;
  logic                 sign2_reg,   sign2_next;
  logic [2*WIDTH-1:0]   result_reg,  result_next;
  logic                 ready_reg,   ready_next;

  // Datapath helpers
  logic [WIDTH:0]       minuend;
  logic [WIDTH-1:0]     op1_abs, op2_abs;
  logic [WIDTH-1:0]     quot, rem, quot_fix, rem_fix;

  always_comb begin
    // A partial remainder is below the divisor, so the shifted remainder is
    // below 2*divisor. A W+1-bit difference therefore never overflows, and
    // its top bit is a correct "negative" flag.
    minuend  = work_reg[2*WIDTH:WIDTH] - {1'b0, divisor_reg};
    op1_abs  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    op2_abs  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    quot     = work_reg[WIDTH-1:0];
    rem      = work_reg[2*WIDTH:WIDTH+1];
    // The quotient takes the XOR of the operand signs.
    // The remainder follows the dividend's sign.
    quot_fix = (signed_reg && (sign1_reg ^ sign2_reg)) ? -quot : quot;
    rem_fix  = (signed_reg && sign1_reg) ? -rem : rem;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    work_next    = work_reg;
    divisor_next = divisor_reg;
    signed_next  = signed_reg;
    sign1_next   = sign1_reg;
    sign2_next   = sign2_reg;
    result_next  = result_reg;
    ready_next   = ready_reg;

    case (state_reg)
      FREE: begin
        ready_next  = 1'b0;
        result_next = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = BY_ZERO;
          end else begin
            state_next   = ON;
            divisor_next = op2_abs;
            signed_next  = signed_div_i;
            sign1_next   = opdata1_i[WIDTH-1];
            sign2_next   = opdata2_i[WIDTH-1];
            work_next    = {{WIDTH{1'b0}}, op1_abs, 1'b0};
            cnt_next     = '0;
          end
        end
      end

      BY_ZERO: begin
        work_next   = '0;
        result_next = '0;
        ready_next  = 1'b1;
        state_next  = END;
      end

      ON: begin
        if (annul_i) begin
          state_next  = FREE;
          ready_next  = 1'b0;
          result_next = '0;
        end else if (cnt_reg != CW'(WIDTH)) begin
          // Restoring step: keep the subtraction only when it does not go negative.
          if (minuend[WIDTH])
            work_next = {work_reg[2*WIDTH-1:0], 1'b0};
          else
            work_next = {minuend[WIDTH-1:0], work_reg[WIDTH-1:0], 1'b1};
          cnt_next = cnt_reg + CW'(1);
        end else begin
          result_next = {rem_fix, quot_fix};
          ready_next  = 1'b1;
          state_next  = END;
        end
      end

      END: begin
        // Only the requester's release ends the handshake. annul_i has no effect here.
        if (!start_i) begin
          state_next  = FREE;
          ready_next  = 1'b0;
          result_next = '0;
        end
      end

      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= FREE;
      cnt_reg     <= '0;
      work_reg    <= '0;
      divisor_reg <= '0;
      signed_reg  <= 1'b0;
      sign1_reg   <= 1'b0;
      sign2_reg   <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      work_reg    <= work_next;
      divisor_reg <= divisor_next;
      signed_reg  <= signed_next;
      sign1_reg   <= sign1_next;
      sign2_reg   <= sign2_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed and scoreboard checks for div_unit.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [63:0] sb[$];

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait for ready, check latency and result, then release.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
    int lat;
    int n;
    logic [63:0] exp;
    @(negedge clk);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    sb.push_back({r, q});
    lat = (b == 32'd0) ? 1 : 33;
    @(posedge clk);            // edge 0: acceptance
    #1;
    signed_div = ~sgn; op1 = $urandom; op2 = $urandom;   // must be ignored
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    exp = sb.pop_front();
    chk({tag, " result"}, result, exp);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " release ready"}, {63'd0, ready}, 64'd0);
    chk({tag, " release result"}, result, 64'd0);
    $display("txn %s: sgn=%0d %h / %h -> %h after %0d edges", tag, sgn, a, b, exp, n);
  endtask

  // Reference result for random operands (excluding zero divisor and signed overflow).
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] m;
    logic [31:0] ra, rb;
    logic rs;
    int n;

    // Reset state
    #1;
    chk("reset ready", {63'd0, ready}, 64'd0);
    chk("reset result", result, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_div("u100/7",   1'b0, 32'd100,      32'd7,        32'd14,       32'd2);
    do_div("s-7/2",    1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF);
    do_div("s7/-2",    1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
    do_div("u/0",      1'b0, 32'h1234,     32'd0,        32'd0,        32'd0);
    do_div("s/0",      1'b1, 32'h1234,     32'd0,        32'd0,        32'd0);
    do_div("smin/-1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    do_div("umax/1",   1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0);

    // Random operands checked against the model
    for (int i = 0; i < 4; i++) begin
      rs = i[0];
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd5;
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      m = model(rs, ra, rb);
      do_div($sformatf("rand%0d", i), rs, ra, rb, m[31:0], m[63:32]);
    end

    // Annul at iteration 10. The combined start/annul that follows must not re-accept.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);                    // acceptance
    repeat (10) @(posedge clk);        // iterations 1..10
    @(negedge clk) annul = 1'b1;
    @(posedge clk); #1;
    chk("annul ready", {63'd0, ready}, 64'd0);
    @(posedge clk);                    // FREE with start=1, annul=1: no acceptance
    @(negedge clk) begin start = 1'b0; annul = 1'b0; end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    chk("annul ready never rises", 64'(n), 64'd0);
    $display("txn annul: ready high on %0d edges after abort", n);
    do_div("u9/3 after annul", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Asynchronous reset at iteration 20
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0; start = 1'b0;
    #1;
    chk("midON rst ready", {63'd0, ready}, 64'd0);
    chk("midON rst result", result, 64'd0);
    @(negedge clk) rst = 1'b1;
    $display("txn reset mid-ON applied");
    do_div("u1000/3 after rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);

    // Asynchronous reset while a result is held: outputs must drop without a clock edge
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd6; start = 1'b1;
    sb.push_back({32'd2, 32'd8});
    @(posedge clk);
    n = 0;
    #1;
    while (!ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("END latency", 64'(n), 64'd33);
    m = sb.pop_front();
    chk("END result", result, m);
    #2 rst = 1'b0; start = 1'b0;
    #1;
    chk("END rst ready", {63'd0, ready}, 64'd0);
    chk("END rst result", result, 64'd0);
    @(negedge clk) rst = 1'b1;
    $display("txn reset in END: ready=%0d result=%h", ready, result);
    do_div("s-100/7 after rst", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
